lpc_capture_sched: RTL

LPC_CAPTURE_SCHED -- requirements
Module: lpc_capture_sched

---
 rtl/lpc_capture_sched.sv | 139 +++++++++++++
 1 files changed

// File: rtl/lpc_capture_sched.sv
// LPC cycle capture: filters decoded LPC cycles, buffers them as records in a
// small FIFO and serialises each record as six bytes on a valid/ready stream.
module lpc_capture_sched #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic        in_strobe,
    input  logic [3:0]  in_cyctype_dir,
    input  logic [31:0] in_addr,
    input  logic [7:0]  in_data,
    input  logic        io_en,
    input  logic        mem_en,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [7:0]  drop_count,
    output logic [4:0]  fifo_level,
    output logic [3:0]  dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Record layout: {lost[44], cyctype_dir[43:40], addr[39:8], data[7:0]}
    logic [44:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [4:0]       level, level_next;
    logic             strobe_q;
    logic             lost;
    logic [7:0]       drops;
    state_t           state, state_next;
    logic [2:0]       index, index_next;

    logic             capture, qualified, push, pop, drop;
    logic [44:0]      head;

    always_comb begin
        capture   = in_strobe & ~strobe_q;
        qualified = capture &&
                    ((in_cyctype_dir[3:2] == 2'b00 && io_en) ||
                     (in_cyctype_dir[3:2] == 2'b01 && mem_en));
        pop       = (state == SEND) && out_ready && (index == 3'd5);
        // A full FIFO still accepts when the head leaves in the same cycle.
        push      = qualified && ((level != DEPTH_L) || pop);
        drop      = qualified && !push;
        case ({push, pop})
            2'b10:   level_next = level + 5'd1;
            2'b01:   level_next = level - 5'd1;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            strobe_q <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drops    <= '0;
            lost     <= 1'b0;
            state    <= IDLE;
            index    <= '0;
        end else begin
            strobe_q <= in_strobe;
            level    <= level_next;
            state    <= state_next;
            index    <= index_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop && drops != 8'hFF) drops <= drops + 8'd1;
            if (push)      lost <= 1'b0;
            else if (drop) lost <= 1'b1;
        end
    end

    always_ff @(posedge lpc_clock) begin
        if (push) mem[wr_ptr] <= {lost, in_cyctype_dir, in_addr, in_data};
    end

    // Stream handshake: a byte transfers on a rising edge where out_valid and
    // out_ready are both high; while out_valid is high without out_ready the
    // byte, out_last and the index hold, and out_valid stays asserted.
    always_comb begin
        state_next = state;
        index_next = index;
        case (state)
            IDLE: begin
                if (level != 5'd0 || push) begin
                    state_next = SEND;
                    index_next = 3'd0;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (index == 3'd5) begin
                        index_next = 3'd0;
                        if (level_next == 5'd0) state_next = IDLE;
                    end else begin
                        index_next = index + 3'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                index_next = 3'd0;
            end
        endcase
    end

    always_comb begin
        head     = mem[rd_ptr];
        out_byte = 8'h00;
        if (state == SEND) begin
            case (index)
                3'd0:    out_byte = {head[44], 3'b000, head[43:40]};
                3'd1:    out_byte = head[39:32];
                3'd2:    out_byte = head[31:24];
                3'd3:    out_byte = head[23:16];
                3'd4:    out_byte = head[15:8];
                3'd5:    out_byte = head[7:0];
                default: out_byte = 8'h00;
            endcase
        end
    end

    assign out_valid  = (state == SEND);
    assign out_last   = (state == SEND) && (index == 3'd5);
    assign drop_count = drops;
    assign fifo_level = level;
    assign dbg_state  = {state, index};

endmodule
